// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES key-schedule store:
//   - key-length encodings and the per-length Nk / Nr / key-size lookups
//   - FSM state encoding for the expansion engine
//   - the AES forward S-box table with a byte lookup helper
//   - xtime (GF(2^8) multiply by x), used to step the round constant
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        KEY_128  = 2'd0,
        KEY_192  = 2'd1,
        KEY_256  = 2'd2,
        KEY_RSVD = 2'd3
    } key_len_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DONE   = 2'd3
    } ks_state_e;

    // Number of 32-bit words in the cipher key.
    function automatic logic [3:0] keyNk(input key_len_e len);
        case (len)
            KEY_128: keyNk = 4'd4;
            KEY_192: keyNk = 4'd6;
            default: keyNk = 4'd8;
        endcase
    endfunction

    // Number of cipher rounds (Nk + 6).
    function automatic logic [3:0] keyNr(input key_len_e len);
        keyNr = keyNk(len) + 4'd6;
    endfunction

    // Key size in bits; the reserved code maps to 0 and is rejected separately.
    function automatic int keyBits(input key_len_e len);
        case (len)
            KEY_128: keyBits = 128;
            KEY_192: keyBits = 192;
            KEY_256: keyBits = 256;
            default: keyBits = 0;
        endcase
    endfunction

    // Largest round count a build can hold, from its maximum key size.
    function automatic int maxNr(input int maxKeyBits);
        if (maxKeyBits <= 128)
            maxNr = 10;
        else if (maxKeyBits <= 192)
            maxNr = 12;
        else
            maxNr = 14;
    endfunction

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        sbox = SBOX_TABLE[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// -----------------------------------------------------------------------------
// aes_subword
// SubWord: four parallel combinational S-box lookups on a 32-bit word.
// Ports:
//   word_i  in  32  word to substitute
//   word_o  out 32  byte-wise S-box result
// -----------------------------------------------------------------------------
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                     sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/key_schedule_store.sv
// -----------------------------------------------------------------------------
// key_schedule_store
// AES-128/192/256 key-schedule engine and round-key store. A start pulse
// loads the cipher key and expands it one word per cycle into a word array;
// once complete, any round key is returned with a one-cycle read latency.
// Ports:
//   clk         in   1    clock
//   rst_n       in   1    asynchronous active-low reset
//   start_i     in   1    start expansion (single-cycle pulse)
//   key_len_i   in   2    0=128, 1=192, 2=256, 3=reserved; sampled with start_i
//   key_in      in   256  cipher key, MSB-justified (word 0 = [255:224])
//   busy_o      out  1    expansion in progress
//   ready_o     out  1    full schedule valid for the current key
//   nr_o        out  4    round count of the current key (0 after reset)
//   cfg_err_o   out  1    pulse: start rejected
//   rd_en_i     in   1    round-key read request
//   rd_round_i  in   4    round index 0..Nr
//   rd_key_o    out  128  round key, word 4r in [127:96]
//   rd_valid_o  out  1    pulse: rd_key_o updated with a valid key
//   rd_err_o    out  1    pulse: read refused
// -----------------------------------------------------------------------------
module key_schedule_store
    import aes_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [1:0]   key_len_i,
    input  logic [255:0] key_in,
    output logic         busy_o,
    output logic         ready_o,
    output logic [3:0]   nr_o,
    output logic         cfg_err_o,
    input  logic         rd_en_i,
    input  logic [3:0]   rd_round_i,
    output logic [127:0] rd_key_o,
    output logic         rd_valid_o,
    output logic         rd_err_o
);

    localparam int NR_MAX = maxNr(MAX_KEY_BITS);
    localparam int DEPTH  = 4 * (NR_MAX + 1);

    ks_state_e      state_q, state_d;
    logic [5:0]     wordIdx_q, wordIdx_d;
    logic [2:0]     modCnt_q, modCnt_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [3:0]     nk_q;
    logic [3:0]     nr_q;
    logic [5:0]     lastIdx_q;
    logic           busy_q;
    logic           ready_q;
    logic           cfgErr_q;
    logic           rdValid_q;
    logic           rdErr_q;
    logic [127:0]   rdKey_q;

    logic [31:0]    mem_q [DEPTH];

    key_len_e       keyLenReq;
    logic           startLegal;
    logic           startAccept;
    logic           startReject;
    logic           loadEn;
    logic           wrEn;
    logic           expandLast;
    logic           rdOk;
    logic [5:0]     rdBase;

    logic [31:0]    prevWord;
    logic [31:0]    backWord;
    logic [31:0]    subIn;
    logic [31:0]    subOut;
    logic [31:0]    temp;
    logic [31:0]    newWord;

    // Start qualification: a start is taken only from IDLE or DONE with a
    // supported key size; anything else (including a start while busy)
    // produces a cfg_err pulse and leaves the engine alone.
    assign keyLenReq   = key_len_e'(key_len_i);
    assign startLegal  = (keyLenReq != KEY_RSVD) && (keyBits(keyLenReq) <= MAX_KEY_BITS);
    assign startAccept = start_i && startLegal &&
                         ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign startReject = start_i && !startAccept;

    assign expandLast  = (state_q == ST_EXPAND) && (wordIdx_q == lastIdx_q);

    // Expansion datapath: w[i-1] and w[i-Nk] are read from the array, the
    // wrap counter modCnt_q stands in for i mod Nk.
    assign prevWord = mem_q[wordIdx_q - 6'd1];
    assign backWord = mem_q[wordIdx_q - {2'b00, nk_q}];
    assign subIn    = (modCnt_q == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;

    aes_subword uSubword (
        .word_i (subIn),
        .word_o (subOut)
    );

    always_comb begin
        temp = prevWord;
        if (modCnt_q == 3'd0)
            temp = subOut ^ {rcon_q, 24'h000000};
        else if ((nk_q == 4'd8) && (modCnt_q == 3'd4))
            temp = subOut;
    end

    assign newWord = backWord ^ temp;

    // FSM state register and expansion counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wordIdx_q <= '0;
            modCnt_q  <= '0;
            rcon_q    <= 8'h01;
        end else begin
            state_q   <= state_d;
            wordIdx_q <= wordIdx_d;
            modCnt_q  <= modCnt_d;
            rcon_q    <= rcon_d;
        end
    end

    // Next-state logic: LOAD writes the key words and primes the counters,
    // EXPAND produces one word per cycle and exits after writing w[W-1].
    always_comb begin
        state_d   = state_q;
        wordIdx_d = wordIdx_q;
        modCnt_d  = modCnt_q;
        rcon_d    = rcon_q;
        loadEn    = 1'b0;
        wrEn      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (startAccept)
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                loadEn    = 1'b1;
                wordIdx_d = {2'b00, nk_q};
                modCnt_d  = 3'd0;
                rcon_d    = 8'h01;
                state_d   = ST_EXPAND;
            end
            ST_EXPAND: begin
                wrEn      = 1'b1;
                wordIdx_d = wordIdx_q + 6'd1;
                if (modCnt_q == 3'd0)
                    rcon_d = xtime(rcon_q);
                if ({1'b0, modCnt_q} == (nk_q - 4'd1))
                    modCnt_d = 3'd0;
                else
                    modCnt_d = modCnt_q + 3'd1;
                if (wordIdx_q == lastIdx_q)
                    state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Word storage, deliberately not reset. LOAD fills words 0..Nk-1 in a
    // single cycle; EXPAND writes one word at the current index.
    always_ff @(posedge clk) begin
        if (loadEn) begin
            for (int j = 0; j < 8; j++) begin
                if (4'(j) < nk_q)
                    mem_q[6'(j)] <= key_in[255 - 32*j -: 32];
            end
        end
        if (wrEn)
            mem_q[wordIdx_q] <= newWord;
    end

    // Status and key parameters. Accepting a start drops ready at once so
    // old keys are never served; the last expansion write raises it again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            nr_q      <= 4'd0;
            nk_q      <= 4'd4;
            lastIdx_q <= 6'd0;
            cfgErr_q  <= 1'b0;
        end else begin
            cfgErr_q <= startReject;
            if (startAccept) begin
                busy_q    <= 1'b1;
                ready_q   <= 1'b0;
                nr_q      <= keyNr(keyLenReq);
                nk_q      <= keyNk(keyLenReq);
                lastIdx_q <= {keyNr(keyLenReq), 2'b11};
            end else if (expandLast) begin
                busy_q  <= 1'b0;
                ready_q <= 1'b1;
            end
        end
    end

    // Read port. A start accepted in the same cycle wins over a read, so the
    // read is refused even though ready is still high at that edge. On a
    // refused read the previous key is held.
    assign rdBase = {rd_round_i, 2'b00};
    assign rdOk   = rd_en_i && ready_q && (rd_round_i <= nr_q) && !startAccept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdValid_q <= 1'b0;
            rdErr_q   <= 1'b0;
            rdKey_q   <= '0;
        end else begin
            rdValid_q <= rdOk;
            rdErr_q   <= rd_en_i && !rdOk;
            if (rdOk)
                rdKey_q <= {mem_q[rdBase], mem_q[rdBase + 6'd1],
                            mem_q[rdBase + 6'd2], mem_q[rdBase + 6'd3]};
        end
    end

    assign busy_o     = busy_q;
    assign ready_o    = ready_q;
    assign nr_o       = nr_q;
    assign cfg_err_o  = cfgErr_q;
    assign rd_key_o   = rdKey_q;
    assign rd_valid_o = rdValid_q;
    assign rd_err_o   = rdErr_q;

endmodule

// File: tb/tb_key_schedule_store.sv
// -----------------------------------------------------------------------------
// tb_key_schedule_store
// Directed bench for key_schedule_store: FIPS-197 key vectors for all three
// key sizes, completion timing, read errors, start rejection, restart and
// reset behaviour. A second instance built for 128-bit keys only covers the
// oversize-key rejection.
// -----------------------------------------------------------------------------
module tb_key_schedule_store;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   keyLen;
    logic [255:0] keyIn;
    logic         busy;
    logic         ready;
    logic [3:0]   nr;
    logic         cfgErr;
    logic         rdEn;
    logic [3:0]   rdRound;
    logic [127:0] rdKey;
    logic         rdValid;
    logic         rdErr;

    logic         start2;
    logic [1:0]   keyLen2;
    logic         busy2;
    logic         ready2;
    logic [3:0]   nr2;
    logic         cfgErr2;
    logic         rdEn2;
    logic [3:0]   rdRound2;
    logic [127:0] rdKey2;
    logic         rdValid2;
    logic         rdErr2;

    int passCount;
    int checkCount;

    logic [31:0] refW [60];

    key_schedule_store #(.MAX_KEY_BITS(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .key_len_i  (keyLen),
        .key_in     (keyIn),
        .busy_o     (busy),
        .ready_o    (ready),
        .nr_o       (nr),
        .cfg_err_o  (cfgErr),
        .rd_en_i    (rdEn),
        .rd_round_i (rdRound),
        .rd_key_o   (rdKey),
        .rd_valid_o (rdValid),
        .rd_err_o   (rdErr)
    );

    key_schedule_store #(.MAX_KEY_BITS(128)) dut128 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start2),
        .key_len_i  (keyLen2),
        .key_in     (keyIn),
        .busy_o     (busy2),
        .ready_o    (ready2),
        .nr_o       (nr2),
        .cfg_err_o  (cfgErr2),
        .rd_en_i    (rdEn2),
        .rd_round_i (rdRound2),
        .rd_key_o   (rdKey2),
        .rd_valid_o (rdValid2),
        .rd_err_o   (rdErr2)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, summary %0d/%0d", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge; all driving and sampling
    // happens here, away from the edge itself.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startKey(input logic [1:0] len, input logic [255:0] key);
        keyLen = len;
        keyIn  = key;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Counts edges after the start edge until ready_o is seen (bounded).
    task automatic waitReady(output int cycles);
        cycles = 0;
        while (!ready && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic readRound(input int r);
        rdEn    = 1'b1;
        rdRound = 4'(r);
        tick();
        rdEn    = 1'b0;
    endtask

    function automatic logic [31:0] subWordRef(input logic [31:0] x);
        subWordRef = {aes_pkg::sbox(x[31:24]), aes_pkg::sbox(x[23:16]),
                      aes_pkg::sbox(x[15:8]),  aes_pkg::sbox(x[7:0])};
    endfunction

    // Straightforward FIPS-197 key expansion into refW.
    task automatic computeRef(input logic [255:0] key, input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++)
            refW[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nk+7); i++) begin
            t = refW[i-1];
            if (i % nk == 0) begin
                t  = subWordRef({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % nk == 4) begin
                t = subWordRef(t);
            end
            refW[i] = refW[i-nk] ^ t;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checkCount++;
        if ({busy, ready, nr, cfgErr, rdValid, rdErr} !== 9'd0)
            $display("[TB] FAIL reset_status: got %b, expected 000000000", {busy, ready, nr, cfgErr, rdValid, rdErr});
        else
            passCount++;
        checkCount++;
        if (rdKey !== 128'd0)
            $display("[TB] FAIL reset_rdkey: got %h, expected 0", rdKey);
        else
            passCount++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cfg_errors();
        keyLen = 2'd3;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        checkCount++;
        if (cfgErr !== 1'b1)
            $display("[TB] FAIL cfgerr_reserved: got %b, expected 1", cfgErr);
        else
            passCount++;
        checkCount++;
        if ({busy, ready, nr} !== 6'd0)
            $display("[TB] FAIL reserved_stays_idle: busy/ready/nr got %b, expected 000000", {busy, ready, nr});
        else
            passCount++;
        tick();
        checkCount++;
        if (cfgErr !== 1'b0)
            $display("[TB] FAIL cfgerr_pulse_width: got %b, expected 0", cfgErr);
        else
            passCount++;

        keyLen2 = 2'd2;
        start2  = 1'b1;
        tick();
        start2  = 1'b0;
        checkCount++;
        if ({cfgErr2, busy2} !== 2'b10)
            $display("[TB] FAIL max128_rejects_256: cfgerr/busy got %b, expected 10", {cfgErr2, busy2});
        else
            passCount++;

        keyLen2 = 2'd0;
        start2  = 1'b1;
        tick();
        start2  = 1'b0;
        checkCount++;
        if ({cfgErr2, busy2, nr2} !== {2'b01, 4'd10})
            $display("[TB] FAIL max128_accepts_128: cfgerr/busy/nr got %b, expected 011010", {cfgErr2, busy2, nr2});
        else
            passCount++;
    endtask

    task automatic test_aes128();
        int cycles;
        startKey(2'd0, KEY128);
        checkCount++;
        if ({busy, ready, nr} !== {2'b10, 4'd10})
            $display("[TB] FAIL aes128_accept: busy/ready/nr got %b, expected 101010", {busy, ready, nr});
        else
            passCount++;
        waitReady(cycles);
        checkCount++;
        if (cycles !== 41 || busy !== 1'b0)
            $display("[TB] FAIL aes128_ready_time: ready after %0d cycles busy=%b, expected 41 busy=0", cycles, busy);
        else
            passCount++;
        readRound(1);
        checkCount++;
        if (rdValid !== 1'b1 || rdKey !== 128'ha0fafe1788542cb123a339392a6c7605)
            $display("[TB] FAIL aes128_round1: valid=%b key=%h, expected valid=1 key=a0fafe1788542cb123a339392a6c7605", rdValid, rdKey);
        else
            passCount++;
        readRound(10);
        checkCount++;
        if (rdValid !== 1'b1 || rdKey !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
            $display("[TB] FAIL aes128_round10: valid=%b key=%h, expected valid=1 key=d014f9a8c9ee2589e13f0cc8b6630ca6", rdValid, rdKey);
        else
            passCount++;
        readRound(11);
        checkCount++;
        if ({rdErr, rdValid} !== 2'b10 || rdKey !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
            $display("[TB] FAIL aes128_round11_err: err/valid=%b key=%h, expected 10 with key held at d014f9a8c9ee2589e13f0cc8b6630ca6", {rdErr, rdValid}, rdKey);
        else
            passCount++;
        tick();
        checkCount++;
        if (rdErr !== 1'b0)
            $display("[TB] FAIL rderr_pulse_width: got %b, expected 0", rdErr);
        else
            passCount++;
    endtask

    // Rounds 0..Nr read one per cycle against the reference expansion.
    task automatic test_back_to_back(input logic [255:0] key, input int nk);
        logic [127:0] expKey;
        int nrExp;
        nrExp = nk + 6;
        computeRef(key, nk);
        for (int r = 0; r <= nrExp; r++) begin
            rdEn    = 1'b1;
            rdRound = 4'(r);
            tick();
            expKey = {refW[4*r], refW[4*r+1], refW[4*r+2], refW[4*r+3]};
            checkCount++;
            if (rdValid !== 1'b1 || rdKey !== expKey)
                $display("[TB] FAIL b2b_nk%0d_round%0d: valid=%b key=%h, expected valid=1 key=%h", nk, r, rdValid, rdKey, expKey);
            else
                passCount++;
        end
        rdEn = 1'b0;
    endtask

    task automatic test_aes192();
        int cycles;
        startKey(2'd1, KEY192);
        waitReady(cycles);
        checkCount++;
        if (cycles !== 47 || nr !== 4'd12)
            $display("[TB] FAIL aes192_ready_time: ready after %0d cycles nr=%0d, expected 47 and 12", cycles, nr);
        else
            passCount++;
        readRound(12);
        checkCount++;
        if (rdValid !== 1'b1 || rdKey !== 128'he98ba06f448c773c8ecc720401002202)
            $display("[TB] FAIL aes192_round12: valid=%b key=%h, expected valid=1 key=e98ba06f448c773c8ecc720401002202", rdValid, rdKey);
        else
            passCount++;
    endtask

    task automatic test_aes256();
        int cycles;
        startKey(2'd2, KEY256);
        waitReady(cycles);
        checkCount++;
        if (cycles !== 53 || nr !== 4'd14)
            $display("[TB] FAIL aes256_ready_time: ready after %0d cycles nr=%0d, expected 53 and 14", cycles, nr);
        else
            passCount++;
        readRound(14);
        checkCount++;
        if (rdValid !== 1'b1 || rdKey !== 128'hfe4890d1e6188d0b046df344706c631e)
            $display("[TB] FAIL aes256_round14: valid=%b key=%h, expected valid=1 key=fe4890d1e6188d0b046df344706c631e", rdValid, rdKey);
        else
            passCount++;
        readRound(0);
        checkCount++;
        if (rdValid !== 1'b1 || rdKey !== 128'h603deb1015ca71be2b73aef0857d7781)
            $display("[TB] FAIL aes256_round0: valid=%b key=%h, expected valid=1 key=603deb1015ca71be2b73aef0857d7781", rdValid, rdKey);
        else
            passCount++;
    endtask

    // A restart from DONE drops ready immediately and reads the old keys
    // no longer; mid-expansion reads are refused too.
    task automatic test_read_busy();
        int cycles;
        startKey(2'd0, KEY128);
        checkCount++;
        if (ready !== 1'b0)
            $display("[TB] FAIL restart_drops_ready: got %b, expected 0", ready);
        else
            passCount++;
        tick();
        tick();
        readRound(0);
        checkCount++;
        if ({rdErr, rdValid} !== 2'b10)
            $display("[TB] FAIL read_while_busy: err/valid got %b, expected 10", {rdErr, rdValid});
        else
            passCount++;
        waitReady(cycles);
    endtask

    task automatic test_restart_mid();
        int cycles;
        startKey(2'd0, KEY128);
        cycles = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            cycles++;
        end
        keyLen = 2'd2;
        start  = 1'b1;
        tick();
        cycles++;
        start  = 1'b0;
        checkCount++;
        if ({cfgErr, busy, nr} !== {2'b11, 4'd10})
            $display("[TB] FAIL start_while_busy: cfgerr/busy/nr got %b, expected 111010", {cfgErr, busy, nr});
        else
            passCount++;
        while (!ready && cycles < 200) begin
            tick();
            cycles++;
        end
        checkCount++;
        if (cycles !== 41)
            $display("[TB] FAIL restart_mid_timing: ready after %0d cycles, expected 41", cycles);
        else
            passCount++;
        readRound(10);
        checkCount++;
        if (rdValid !== 1'b1 || rdKey !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
            $display("[TB] FAIL restart_mid_round10: valid=%b key=%h, expected valid=1 key=d014f9a8c9ee2589e13f0cc8b6630ca6", rdValid, rdKey);
        else
            passCount++;
    endtask

    // Start while DONE with a read in the same cycle: the start wins.
    task automatic test_start_read_same();
        int cycles;
        keyLen  = 2'd0;
        keyIn   = KEY128;
        start   = 1'b1;
        rdEn    = 1'b1;
        rdRound = 4'd1;
        tick();
        start   = 1'b0;
        rdEn    = 1'b0;
        checkCount++;
        if ({rdErr, rdValid, ready, busy} !== 4'b1001)
            $display("[TB] FAIL start_beats_read: err/valid/ready/busy got %b, expected 1001", {rdErr, rdValid, ready, busy});
        else
            passCount++;
        waitReady(cycles);
    endtask

    task automatic test_reset_mid();
        int cycles;
        startKey(2'd2, KEY256);
        for (int i = 0; i < 20; i++)
            tick();
        rst_n = 1'b0;
        #1;
        checkCount++;
        if ({busy, ready, nr, cfgErr, rdValid, rdErr} !== 9'd0 || rdKey !== 128'd0)
            $display("[TB] FAIL reset_mid_outputs: status=%b key=%h, expected all 0", {busy, ready, nr, cfgErr, rdValid, rdErr}, rdKey);
        else
            passCount++;
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        checkCount++;
        if ({busy, ready} !== 2'b00)
            $display("[TB] FAIL reset_mid_stays_idle: busy/ready got %b, expected 00", {busy, ready});
        else
            passCount++;
        startKey(2'd0, KEY128);
        waitReady(cycles);
        checkCount++;
        if (cycles !== 41)
            $display("[TB] FAIL post_reset_timing: ready after %0d cycles, expected 41", cycles);
        else
            passCount++;
        readRound(1);
        checkCount++;
        if (rdValid !== 1'b1 || rdKey !== 128'ha0fafe1788542cb123a339392a6c7605)
            $display("[TB] FAIL post_reset_round1: valid=%b key=%h, expected valid=1 key=a0fafe1788542cb123a339392a6c7605", rdValid, rdKey);
        else
            passCount++;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        start      = 1'b0;
        keyLen     = 2'd0;
        keyIn      = '0;
        rdEn       = 1'b0;
        rdRound    = 4'd0;
        start2     = 1'b0;
        keyLen2    = 2'd0;
        rdEn2      = 1'b0;
        rdRound2   = 4'd0;
        rst_n      = 1'b0;

        $display("[TB] key_schedule_store directed tests");
        test_reset();
        test_cfg_errors();
        test_aes128();
        test_back_to_back(KEY128, 4);
        test_read_busy();
        test_restart_mid();
        test_start_read_same();
        test_aes192();
        test_back_to_back(KEY192, 6);
        test_aes256();
        test_back_to_back(KEY256, 8);
        test_reset_mid();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
